spi_fifo_irq_ctrl: RTL and testbench
====================================

# spi_fifo_irq_ctrl

Host-side buffering and interrupt stage placed directly upstream of the SPI master. Host words go into a TX FIFO and are launched one at a time into the master with a single-cycle start pulse. Each word the master returns is captured into an RX FIFO. FIFO and transfer events are aggregated into a maskable, sticky interrupt line.

## Interface
Parameters:
- DATA_WIDTH, 16, SPI word width; must match the master.
- TX_DEPTH, 8, TX FIFO entries; power of two, ≥2.
- RX_DEPTH, 8, RX FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  permit launching new transfers
- wr_en  in  1  host push to TX FIFO
- wr_data  in  DATA_WIDTH  host TX word
- wr_full  out  1  TX FIFO full
- rd_en  in  1  host pop from RX FIFO
- rd_data  out  DATA_WIDTH  RX head word (show-ahead); 0 when empty
- rd_empty  out  1  RX FIFO empty
- tx_flush, rx_flush  in  1 each  synchronous FIFO clear
- tx_level  out  $clog2(TX_DEPTH)+1  TX occupancy
- rx_level  out  $clog2(RX_DEPTH)+1  RX occupancy
- irq_mask  in  5  per-bit enable
- irq_clr  in  5  write-1-to-clear pulse for the sticky bits
- irq_status  out  5  raw status: [0] TX_EMPTY, [1] RX_AVAIL, [2] RX_OVF, [3] XFER_DONE, [4] TX_OVF
- irq  out  1  registered OR of (irq_status & irq_mask)
- spi_start  out  1  one-cycle launch pulse to the master
- spi_tx_data  out  DATA_WIDTH  word for the master; held stable from launch until done
- spi_busy  in  1  master busy
- spi_done  in  1  master completion pulse; spi_rx_data is valid in that cycle
- spi_rx_data  in  DATA_WIDTH  word returned by the master

## Operation
- Reset values:
  - all levels 0; wr_full=0; rd_empty=1; rd_data=0
  - spi_start=0; spi_tx_data=0; irq=0
  - irq_status=5'b00001 (TX_EMPTY set)
  - state IDLE
- FSM states: IDLE, LAUNCH, WAIT_DONE.
  - IDLE: if enable && tx_level!=0 && !spi_busy, pop the TX head into spi_tx_data and go to LAUNCH.
  - LAUNCH: spi_start=1 for exactly this cycle; go to WAIT_DONE.
  - WAIT_DONE: on spi_done, push spi_rx_data into the RX FIFO, set XFER_DONE, and go to IDLE.
  - spi_done outside WAIT_DONE is ignored.
- TX push:
  - Accepted when not full.
  - A push while full is dropped and sets TX_OVF.
  - A push and a pop in the same cycle are both honoured.
- RX push:
  - Accepted when not full, or when full and rd_en is asserted in the same cycle.
  - Otherwise the word is discarded and RX_OVF is set.
- rd_en while empty is ignored, with no status effect.
- Sticky bits (TX_EMPTY, RX_OVF, XFER_DONE, TX_OVF):
  - Set on the event and held until the matching irq_clr bit is pulsed.
  - A set and a clear in the same cycle: set wins.
  - TX_EMPTY sets on any cycle where tx_level becomes 0 through a pop or a flush.
- RX_AVAIL is a level bit: equals !rd_empty. Its irq_clr bit has no effect.
- Flush:
  - tx_flush empties the TX FIFO. A word already in spi_tx_data still completes.
  - rx_flush empties the RX FIFO without setting any status bit.
  - Flush wins over a push or pop in the same cycle.
- Deasserting enable mid-transfer: the current transfer completes; no further launches.
- Pointers wrap modulo depth; full/empty are derived from the level counters.

## Timing
- Host push to launch:
  - wr_en sampled at edge k gives tx_level=1 after edge k.
  - The pop and spi_tx_data load happen at edge k+1.
  - spi_start is high from edge k+1 to edge k+2.
- Back-to-back transfers: the next spi_start occurs no earlier than 2 cycles after spi_done.
- RX word: spi_done at edge d is visible on rd_data, with rd_empty=0, after edge d.
- irq lags its status change by 1 cycle.
- Level outputs update on the edge that commits the push or pop.

## Test plan
- Reset, then push 0xA5A5 with enable=1 → spi_start one pulse 2 cycles later, spi_tx_data=0xA5A5; TX_EMPTY set after the pop.
- Model the master returning 0x1234 on spi_done → rd_data=0x1234, rd_empty=0, XFER_DONE=1; irq rises one cycle later when mask bit3=1.
- Push 9 words with enable=0, TX_DEPTH=8 → wr_full=1, 9th word dropped, TX_OVF=1; enable → exactly 8 transfers in FIFO order.
- Complete 9 transfers without reading, RX_DEPTH=8 → 9th word lost, RX_OVF=1, rx_level=8; same-cycle rd_en on a full FIFO → word accepted, no RX_OVF.
- irq_clr[3] and a new spi_done in the same cycle → XFER_DONE remains 1; mask=0 → irq=0 with status unchanged.
- Assert rst_n low during WAIT_DONE → all outputs return to reset values immediately; a subsequent spi_done is ignored.

Source files
------------

// File: rtl/spi_fifo_irq_ctrl.sv
// Host-side TX/RX FIFOs, SPI master launch sequencer and sticky, maskable interrupt aggregation.
// One TX word is launched per transfer; each returned word is captured into the RX FIFO.
module spi_fifo_irq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic                        wr_full,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_empty,
  input  logic                        tx_flush,
  input  logic                        rx_flush,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  input  logic [4:0]                  irq_mask,
  input  logic [4:0]                  irq_clr,
  output logic [4:0]                  irq_status,
  output logic                        irq,
  output logic                        spi_start,
  output logic [DATA_WIDTH-1:0]       spi_tx_data,
  input  logic                        spi_busy,
  input  logic                        spi_done,
  input  logic [DATA_WIDTH-1:0]       spi_rx_data
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_LW = TX_AW + 1;
  localparam int RX_LW = RX_AW + 1;
  localparam logic [TX_LW-1:0] TX_FULL_LVL = TX_LW'(TX_DEPTH);
  localparam logic [RX_LW-1:0] RX_FULL_LVL = RX_LW'(RX_DEPTH);
  localparam logic [TX_LW-1:0] TX_ONE      = TX_LW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
  logic [TX_AW-1:0]      tx_wr_ptr, tx_rd_ptr;
  logic [RX_AW-1:0]      rx_wr_ptr, rx_rd_ptr;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic xfer_done;
  logic tx_empty_evt, tx_ovf_evt, rx_ovf_evt;
  logic [4:0] sticky_q, sticky_set;

  // Set wins over a same-cycle clear.
  function automatic logic [4:0] sticky_next(input logic [4:0] cur,
                                             input logic [4:0] set,
                                             input logic [4:0] clr);
    return (cur & ~clr) | set;
  endfunction

  function automatic logic [TX_LW-1:0] tx_level_next(input logic [TX_LW-1:0] lvl,
                                                     input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return lvl + TX_ONE;
      2'b01:   return lvl - TX_ONE;
      default: return lvl;
    endcase
  endfunction

  function automatic logic [RX_LW-1:0] rx_level_next(input logic [RX_LW-1:0] lvl,
                                                     input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return lvl + RX_LW'(1);
      2'b01:   return lvl - RX_LW'(1);
      default: return lvl;
    endcase
  endfunction

  assign tx_full  = (tx_level == TX_FULL_LVL);
  assign tx_empty = (tx_level == '0);
  assign rx_full  = (rx_level == RX_FULL_LVL);
  assign rx_empty = (rx_level == '0);
  assign wr_full  = tx_full;
  assign rd_empty = rx_empty;

  // Launch sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    spi_start = 1'b0;
    xfer_done = 1'b0;
    case (state)
      IDLE: begin
        // A flush in the same cycle wins, so nothing is popped or launched.
        if (enable && !tx_empty && !spi_busy && !tx_flush) begin
          tx_pop    = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        spi_start = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (spi_done) begin
          xfer_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // TX FIFO
  assign tx_push = wr_en && !tx_full && !tx_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
    end else if (tx_flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_level <= tx_level_next(tx_level, tx_push, tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= wr_data;
  end

  // The launched word stays put until the next pop, even across a TX flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      spi_tx_data <= '0;
    else if (tx_pop) spi_tx_data <= tx_mem[tx_rd_ptr];
  end

  // RX FIFO: a full FIFO still accepts when the host pops in the same cycle.
  assign rx_pop  = rd_en && !rx_empty && !rx_flush;
  assign rx_push = xfer_done && (!rx_full || rd_en) && !rx_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
    end else if (rx_flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_level <= rx_level_next(rx_level, rx_push, rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= spi_rx_data;
  end

  assign rd_data = rx_empty ? '0 : rx_mem[rx_rd_ptr];

  // Interrupt status
  assign tx_empty_evt = tx_flush || (tx_pop && !tx_push && (tx_level == TX_ONE));
  assign tx_ovf_evt   = wr_en && tx_full && !tx_flush;
  assign rx_ovf_evt   = xfer_done && rx_full && !rd_en && !rx_flush;
  assign sticky_set   = {tx_ovf_evt, xfer_done, rx_ovf_evt, 1'b0, tx_empty_evt};

  // Bit 1 of the sticky register is held at zero; RX_AVAIL is a live level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 5'b00001;
    else        sticky_q <= sticky_next(sticky_q, sticky_set, irq_clr) & 5'b11101;
  end

  assign irq_status = sticky_q | {3'b000, ~rx_empty, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |(irq_status & irq_mask);
  end

endmodule

// File: tb/tb_spi_fifo_irq_ctrl.sv
// Directed and randomized bench for spi_fifo_irq_ctrl, checked every cycle against a
// queue-based model of the FIFOs, the transfer handshake and the interrupt bits.
module tb_spi_fifo_irq_ctrl;

  localparam int DW  = 16;
  localparam int TXD = 8;
  localparam int RXD = 8;

  logic          clk, rst_n, enable, wr_en, rd_en, tx_flush, rx_flush;
  logic [DW-1:0] wr_data, rd_data, spi_tx_data, spi_rx_data;
  logic          wr_full, rd_empty, irq, spi_start, spi_busy, spi_done;
  logic [3:0]    tx_level, rx_level;
  logic [4:0]    irq_mask, irq_clr, irq_status;

  spi_fifo_irq_ctrl #(.DATA_WIDTH(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .tx_flush(tx_flush), .rx_flush(rx_flush),
    .tx_level(tx_level), .rx_level(rx_level),
    .irq_mask(irq_mask), .irq_clr(irq_clr), .irq_status(irq_status), .irq(irq),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx_data(spi_rx_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [DW-1:0] tq [$];
  logic [DW-1:0] rq [$];
  logic [4:0]    m_st;
  logic          m_irq, m_out, e_start;
  int            m_age;
  logic [DW-1:0] m_word;
  bit            drv_on;
  int            drv_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    tq.delete();
    rq.delete();
    m_st = 5'b00001; m_irq = 1'b0; m_out = 1'b0; m_age = 0;
    m_word = '0; e_start = 1'b0; drv_cnt = 0;
  endtask

  task automatic chk_reset();
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_wr_full", wr_full, 0);
    chk("rst_rd_empty", rd_empty, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_spi_start", spi_start, 0);
    chk("rst_spi_tx_data", spi_tx_data, 0);
    chk("rst_irq", irq, 0);
    chk("rst_irq_status", irq_status, 5'b00001);
  endtask

  // One clock: advance the model from the current inputs, clock, compare, clear pulses.
  task automatic step();
    bit pop, dacc, tacc;
    int tsz, rsz;
    logic [4:0] set_b, st_pre;
    if (drv_on && drv_cnt > 0) begin
      drv_cnt--;
      if (drv_cnt == 0) begin
        spi_done = 1'b1; spi_rx_data = DW'($urandom); spi_busy = 1'b0;
      end
    end
    tsz = tq.size(); rsz = rq.size();
    st_pre = m_st | {3'b000, (rsz != 0), 1'b0};
    pop  = !tx_flush && !m_out && enable && (tsz != 0) && !spi_busy;
    dacc = m_out && (m_age >= 1) && spi_done;
    set_b = '0;
    tacc = wr_en && (tsz < TXD);
    if (tx_flush) begin
      tq.delete(); set_b[0] = 1'b1;
    end else begin
      if (pop) begin
        m_word = tq.pop_front();
        if (tsz == 1 && !tacc) set_b[0] = 1'b1;
      end
      if (wr_en) begin
        if (tacc) tq.push_back(wr_data);
        else      set_b[4] = 1'b1;
      end
    end
    if (dacc) set_b[3] = 1'b1;
    if (rx_flush) rq.delete();
    else begin
      if (rd_en && rsz != 0) rq.delete(0);
      if (dacc) begin
        if (rsz < RXD || rd_en) rq.push_back(spi_rx_data);
        else                    set_b[2] = 1'b1;
      end
    end
    m_st = ((m_st & ~irq_clr) | set_b) & 5'b11101;
    m_irq = |(st_pre & irq_mask);
    if (pop) begin m_out = 1'b1; m_age = 0; end
    else if (dacc) m_out = 1'b0;
    else m_age++;
    e_start = pop;

    @(posedge clk); #1;
    chk("tx_level", tx_level, tq.size());
    chk("wr_full", wr_full, (tq.size() == TXD));
    chk("rx_level", rx_level, rq.size());
    chk("rd_empty", rd_empty, (rq.size() == 0));
    chk("rd_data", rd_data, (rq.size() != 0) ? rq[0] : 16'h0);
    chk("irq_status", irq_status, m_st | {3'b000, (rq.size() != 0), 1'b0});
    chk("irq", irq, m_irq);
    chk("spi_start", spi_start, e_start);
    chk("spi_tx_data", spi_tx_data, m_word);

    if (drv_on && spi_start) begin
      drv_cnt = $urandom_range(2, 5); spi_busy = 1'b1;
    end
    wr_en = 1'b0; rd_en = 1'b0; irq_clr = '0;
    tx_flush = 1'b0; rx_flush = 1'b0; spi_done = 1'b0;
  endtask

  // Bounded wait for a launch, check the word, then complete it one cycle later.
  task automatic xfer(input logic [DW-1:0] txw, input logic [DW-1:0] rxw,
                      input logic [4:0] clr, input bit rden);
    for (int n = 0; n < 12 && spi_start !== 1'b1; n++) step();
    chk("launch_seen", spi_start, 1);
    chk("launch_word", spi_tx_data, txw);
    step();
    spi_done = 1'b1; spi_rx_data = rxw; irq_clr = clr; rd_en = rden;
    step();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    tx_flush = 1'b0; rx_flush = 1'b0; irq_mask = '0; irq_clr = '0;
    spi_busy = 1'b0; spi_done = 1'b0; spi_rx_data = '0; drv_on = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;

    // Push to launch latency and first completion
    enable = 1'b1; wr_en = 1'b1; wr_data = 16'hA5A5; irq_clr = 5'b00001;
    step();
    chk("push_level", tx_level, 1);
    chk("tx_empty_cleared", irq_status[0], 0);
    chk("no_start_yet", spi_start, 0);
    step();
    chk("start_pulse", spi_start, 1);
    chk("start_word", spi_tx_data, 16'hA5A5);
    chk("tx_empty_after_pop", irq_status[0], 1);
    step();
    chk("start_single", spi_start, 0);
    irq_mask = 5'b01000; spi_done = 1'b1; spi_rx_data = 16'h1234;
    step();
    chk("rx_word", rd_data, 16'h1234);
    chk("rx_not_empty", rd_empty, 0);
    chk("xfer_done_set", irq_status[3], 1);
    chk("irq_lags", irq, 0);
    step();
    chk("irq_rises", irq, 1);

    // TX overflow with launches held off, then FIFO-order draining
    rd_en = 1'b1; irq_mask = '0; irq_clr = 5'b11111; enable = 1'b0;
    step();
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = 16'h0100 + 16'(i);
      step();
    end
    chk("tx_full", wr_full, 1);
    chk("tx_full_level", tx_level, 8);
    chk("tx_ovf_set", irq_status[4], 1);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) xfer(16'h0100 + 16'(i), 16'h0200 + 16'(i), 5'b00000, 1'b0);
    repeat (3) step();
    chk("tx_drained", tx_level, 0);
    chk("no_ninth_launch", spi_start, 0);
    chk("rx_filled", rx_level, 8);

    // RX overflow, then a same-cycle pop rescues the incoming word
    wr_en = 1'b1; wr_data = 16'h0BAD;
    step();
    xfer(16'h0BAD, 16'h0300, 5'b00000, 1'b0);
    chk("rx_ovf_set", irq_status[2], 1);
    chk("rx_ovf_level", rx_level, 8);
    chk("rx_ovf_head", rd_data, 16'h0200);
    irq_clr = 5'b00100; wr_en = 1'b1; wr_data = 16'h0C0D;
    step();
    xfer(16'h0C0D, 16'h0400, 5'b00000, 1'b1);
    chk("rx_rescue_no_ovf", irq_status[2], 0);
    chk("rx_rescue_level", rx_level, 8);
    chk("rx_rescue_head", rd_data, 16'h0201);

    // Clear colliding with a set, then masking
    rx_flush = 1'b1;
    step();
    chk("rx_flushed", rd_empty, 1);
    irq_clr = 5'b01000;
    step();
    chk("xfer_done_cleared", irq_status[3], 0);
    wr_en = 1'b1; wr_data = 16'h0E0E;
    step();
    xfer(16'h0E0E, 16'h0555, 5'b01000, 1'b0);
    chk("set_beats_clear", irq_status[3], 1);
    irq_mask = 5'b01000;
    repeat (2) step();
    chk("irq_masked_on", irq, 1);
    irq_mask = '0;
    repeat (2) step();
    chk("irq_masked_off", irq, 0);
    chk("status_kept", irq_status[3], 1);

    // Asynchronous reset during WAIT_DONE
    wr_en = 1'b1; wr_data = 16'h0F0F;
    step();
    for (int n = 0; n < 12 && spi_start !== 1'b1; n++) step();
    chk("launch_before_reset", spi_start, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk_reset();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    spi_done = 1'b1; spi_rx_data = 16'h7777;
    step();
    chk("done_after_reset_ignored", rd_empty, 1);
    chk("status_after_reset", irq_status, 5'b00001);

    // Randomized traffic with a responsive master model
    drv_on = 1'b1;
    for (int i = 0; i < 600; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      wr_en    = ($urandom_range(0, 9) < 4);
      wr_data  = DW'($urandom);
      rd_en    = ($urandom_range(0, 9) < 3);
      irq_mask = 5'($urandom);
      irq_clr  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'b00000;
      tx_flush = ($urandom_range(0, 39) == 0);
      rx_flush = ($urandom_range(0, 39) == 0);
      spi_busy = (drv_cnt > 0) || ($urandom_range(0, 9) == 0);
      if (drv_cnt == 0 && $urandom_range(0, 19) == 0) begin
        spi_done = 1'b1; spi_rx_data = DW'($urandom);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
